isa_io_arbiter: RTL and testbench

Round-robin arbiter and cycle sequencer that shares one ISA I/O bus master port between several internal requesters, such as per-base-address DSP reset/probe engines and a host-side register engine. It grants one requester at a time, drives the shared `address`/`data_out`/`data_dir` bus and the `ior_n`/`iow_n` strobes with programmable setup/strobe/hold timing, honours `iochrdy` wait states, and returns read data plus a one-cycle completion pulse. It sits between the requesters and the ISA pin drivers, so no requester ever drives the shared bus directly.

---
 rtl/isa_io_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_isa_io_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/isa_io_arbiter.sv
// Round-robin arbiter and ISA I/O cycle sequencer sharing one bus master port among NREQ requesters.
// Optional `ISA_IO_TIMEOUT_EN bounds iochrdy wait states to TIMEOUT cycles and flags them on err.
module isa_io_arbiter #(
   parameter int NREQ    = 4,
   parameter int SETUP   = 2,
   parameter int STROBE  = 4,
   parameter int HOLD    = 1,
   parameter int TIMEOUT = 255
) (
   input  logic                 bus_clock,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_we,
   input  logic [NREQ*16-1:0]   req_addr,
   input  logic [NREQ*16-1:0]   req_wdata,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic                 err,
   output logic [15:0]          rdata,
   output logic [15:0]          address,
   output logic [15:0]          data_out,
   input  logic [15:0]          data_in,
   output logic                 data_dir,
   output logic                 ior_n,
   output logic                 iow_n,
   input  logic                 iochrdy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_STROBE, S_WAIT, S_HOLD, S_DONE
   } state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   ptr, sel;
   logic            found;
   logic [15:0]     cnt, cnt_nx;
   logic            we;
   logic            capture;
   logic            strobe_on;
   int              j;
`ifdef ISA_IO_TIMEOUT_EN
   logic            timeout_hit;
   logic            timed_out;
`endif

   // First asserted request at or after ptr, searching cyclically.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      j     = 0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(ptr) + i;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req[j]) begin
            found = 1'b1;
            sel   = PW'(j);
         end
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 16'd1;
      capture  = 1'b0;
`ifdef ISA_IO_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            cnt_nx = '0;
            if (found) state_nx = S_SETUP;
         end
         S_SETUP: begin
            if (cnt == 16'(SETUP - 1)) begin
               state_nx = S_STROBE;
               cnt_nx   = '0;
            end
         end
         S_STROBE: begin
            if (cnt == 16'(STROBE - 1)) begin
               cnt_nx = '0;
               if (iochrdy) begin
                  state_nx = S_HOLD;
                  capture  = 1'b1;
               end else begin
                  state_nx = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (iochrdy) begin
               state_nx = S_HOLD;
               cnt_nx   = '0;
               capture  = 1'b1;
            end else if (cnt == 16'(TIMEOUT - 1)) begin
`ifdef ISA_IO_TIMEOUT_EN
               state_nx    = S_HOLD;
               cnt_nx      = '0;
               timeout_hit = 1'b1;
`else
               // Wait is unbounded; the length counter just saturates.
               cnt_nx = cnt;
`endif
            end
         end
         S_HOLD: begin
            if (cnt == 16'(HOLD - 1)) begin
               state_nx = S_DONE;
               cnt_nx   = '0;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   assign strobe_on = (state_nx == S_STROBE) || (state_nx == S_WAIT);

   // Bus outputs are registered from the next state so pins change cleanly on the edge.
   always_ff @(posedge bus_clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         ptr      <= '0;
         we       <= 1'b0;
         gnt      <= '0;
         done     <= '0;
         rdata    <= '0;
         address  <= '0;
         data_out <= '0;
         data_dir <= 1'b0;
         ior_n    <= 1'b1;
         iow_n    <= 1'b1;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (state == S_IDLE && found) begin
            gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << sel;
            ptr      <= (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
            we       <= req_we[sel];
            address  <= req_addr[int'(sel)*16 +: 16];
            data_out <= req_we[sel] ? req_wdata[int'(sel)*16 +: 16] : 16'h0000;
            data_dir <= req_we[sel];
         end
         if (state == S_DONE) begin
            gnt      <= '0;
            address  <= '0;
            data_out <= '0;
            data_dir <= 1'b0;
         end
         if (capture && !we) rdata <= data_in;
`ifdef ISA_IO_TIMEOUT_EN
         if (timeout_hit && !we) rdata <= 16'hFFFF;
`endif
         ior_n <= !(strobe_on && !we);
         iow_n <= !(strobe_on && we);
         done  <= (state_nx == S_DONE) ? gnt : '0;
      end
   end

`ifdef ISA_IO_TIMEOUT_EN
   always_ff @(posedge bus_clock or negedge reset_n) begin
      if (!reset_n) begin
         timed_out <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (state == S_IDLE) timed_out <= 1'b0;
         else if (timeout_hit) timed_out <= 1'b1;
         err <= (state_nx == S_DONE) && timed_out;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_isa_io_arbiter.sv
// Directed bench for isa_io_arbiter: reset, read, write, fairness, wait states, req drop, async reset.
// The timeout case is compiled in only when ISA_IO_TIMEOUT_EN is defined.
module tb_isa_io_arbiter;

   logic        bus_clock = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [3:0]  req_we;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        err;
   logic [15:0] rdata;
   logic [15:0] address;
   logic [15:0] data_out;
   logic [15:0] data_in;
   logic        data_dir;
   logic        ior_n;
   logic        iow_n;
   logic        iochrdy;

   int tests = 0;
   int fails = 0;

   isa_io_arbiter #(.NREQ(4), .SETUP(2), .STROBE(4), .HOLD(1), .TIMEOUT(8)) dut (
      .bus_clock (bus_clock),
      .reset_n   (reset_n),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .address   (address),
      .data_out  (data_out),
      .data_in   (data_in),
      .data_dir  (data_dir),
      .ior_n     (ior_n),
      .iow_n     (iow_n),
      .iochrdy   (iochrdy)
   );

   always #5 bus_clock = ~bus_clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [3:0] v);
      int r = -1;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   // One transaction from requester k; iochrdy is pulled low on strobe cycles
   // ws_start .. ws_start+ws_len-1 (1-based); with step, data_in tracks the strobe index.
   task automatic do_txn(input string nm, input int k, input bit w,
                         input logic [15:0] a, input logic [15:0] wd, input logic [15:0] din,
                         input bit step, input int ws_start, input int ws_len, input bit drop_early,
                         input int exp_lat, input int exp_low, input int exp_acnt,
                         input bit exp_err, input logic [15:0] exp_rd);
      int lat, low, acnt, dcnt, sidx, wrong;
      @(negedge bus_clock);
      req_we[k] = w;
      req_addr[k*16 +: 16] = a;
      req_wdata[k*16 +: 16] = wd;
      data_in = din;
      req[k] = 1'b1;
      lat = 1; low = 0; acnt = 0; dcnt = 0; sidx = 0; wrong = 0;
      while (1) begin
         @(posedge bus_clock); #1;
         lat++;
         if (done != 4'b0 || lat > 60) break;
         if (drop_early && gnt != 4'b0) begin
            req[k] = 1'b0;
            req_addr[k*16 +: 16] = 16'hFFFF;
         end
         if (w ? !ior_n : !iow_n) wrong++;
         if (!ior_n || !iow_n) begin
            low++;
            sidx++;
         end
         if (address == a) acnt++;
         if (data_dir && data_out == wd) dcnt++;
         data_in = din + (step ? 16'(sidx) : 16'd0);
         iochrdy = !(sidx >= ws_start && sidx < ws_start + ws_len);
      end
      check({nm, "_done"}, done, 64'(4'b1 << k));
      check({nm, "_gnt"}, gnt, 64'(4'b1 << k));
      check({nm, "_latency"}, lat, exp_lat);
      check({nm, "_strobe_low"}, low, exp_low);
      check({nm, "_other_strobe"}, wrong, 0);
      check({nm, "_addr_cycles"}, acnt, exp_acnt);
      check({nm, "_dir_cycles"}, dcnt, w ? exp_acnt : 0);
      check({nm, "_err"}, err, exp_err);
      if (!w) check({nm, "_rdata"}, rdata, exp_rd);
      req[k] = 1'b0;
      iochrdy = 1'b1;
      @(posedge bus_clock); #1;
      check({nm, "_idle_bus"}, {gnt, done, address, data_out, data_dir, ior_n, iow_n},
            {4'b0, 4'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1});
      if (!w) check({nm, "_rdata_held"}, rdata, exp_rd);
   endtask

   initial begin
      int order[5];
      int n, gaps, gapaddr, notoh, c;
      logic [3:0] prev;

      reset_n = 1'b0;
      req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      data_in = '0; iochrdy = 1'b1;
      repeat (3) @(posedge bus_clock);
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_rdata", rdata, 0);
      check("rst_bus", {address, data_out, data_dir}, 0);
      check("rst_strobes", {ior_n, iow_n}, 2'b11);
      @(negedge bus_clock);
      reset_n = 1'b1;

      // Fairness: all four requesting continuously from ptr = 0.
      @(negedge bus_clock);
      for (int k = 0; k < 4; k++) req_addr[k*16 +: 16] = 16'h0300 + 16'(k);
      req_we = 4'b0;
      req = 4'hF;
      n = 0; gaps = 0; gapaddr = 0; notoh = 0; prev = '0; c = 0;
      while (c < 200 && n < 5) begin
         @(posedge bus_clock); #1;
         c++;
         if (gnt != 4'b0 && gnt != prev) begin
            order[n] = onehot_idx(gnt);
            n++;
         end
         if ((gnt & (gnt - 4'd1)) != 4'b0) notoh++;
         if (gnt == 4'b0 && n > 0) begin
            gaps++;
            if (address != 16'h0) gapaddr++;
         end
         prev = gnt;
      end
      req = 4'h0;
      c = 0;
      while (c < 40 && gnt != 4'b0) begin
         @(posedge bus_clock); #1;
         c++;
         if ((gnt & (gnt - 4'd1)) != 4'b0) notoh++;
      end
      check("fair_grants", n, 5);
      for (int i = 0; i < 5; i++) check($sformatf("fair_order%0d", i), order[i], i % 4);
      check("fair_onehot_violations", notoh, 0);
      check("fair_idle_gaps", gaps, 4);
      check("fair_gap_addr_nonzero", gapaddr, 0);
      check("fair_released", gnt, 0);

      do_txn("read", 1, 1'b0, 16'h022A, 16'h0000, 16'h00AA, 1'b0, 0, 0, 1'b0,
             9, 4, 7, 1'b0, 16'h00AA);
      do_txn("write", 0, 1'b1, 16'h0226, 16'h0001, 16'h0000, 1'b0, 0, 0, 1'b0,
             9, 4, 7, 1'b0, 16'h0000);
      do_txn("wait", 1, 1'b0, 16'h0230, 16'h0000, 16'h1000, 1'b1, 2, 6, 1'b0,
             13, 8, 11, 1'b0, 16'h1008);
      do_txn("drop", 3, 1'b0, 16'h0233, 16'h0000, 16'h5A5A, 1'b0, 0, 0, 1'b1,
             9, 4, 7, 1'b0, 16'h5A5A);
`ifdef ISA_IO_TIMEOUT_EN
      do_txn("timeout", 2, 1'b0, 16'h0240, 16'h0000, 16'h1234, 1'b0, 1, 1000, 1'b0,
             17, 12, 15, 1'b1, 16'hFFFF);
`endif

      // Async reset mid-strobe: req[2] leaves ptr at 3, so post-reset grant of 2 shows ptr cleared.
      @(negedge bus_clock);
      req_we[2] = 1'b0; req_we[3] = 1'b0;
      req[2] = 1'b1;
      c = 0;
      while (c < 20 && ior_n) begin
         @(posedge bus_clock); #1;
         c++;
      end
      check("rmid_strobe_started", ior_n, 1'b0);
      @(posedge bus_clock); #1;
      req[3] = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      check("rmid_strobes", {ior_n, iow_n}, 2'b11);
      check("rmid_gnt_done_err", {gnt, done, err}, 0);
      check("rmid_bus", {address, data_out, data_dir}, 0);
      check("rmid_rdata", rdata, 0);
      @(negedge bus_clock);
      reset_n = 1'b1;
      c = 0;
      while (c < 10 && gnt == 4'b0) begin
         @(posedge bus_clock); #1;
         c++;
      end
      check("rmid_regrant", gnt, 4'b0100);
      req = 4'b0;
      c = 0;
      while (c < 40 && done == 4'b0) begin
         @(posedge bus_clock); #1;
         c++;
      end
      check("rmid_done", done, 4'b0100);
      @(posedge bus_clock); #1;
      check("rmid_final_idle", {gnt, ior_n, iow_n}, {4'b0, 2'b11});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1);
   end

endmodule
